dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port data memory (sp_ram, req/gnt/rvalid protocol) between the core data port (m0) and a secondary master such as a loader or debug DMA (m1).
- Sits between the requesters and the data sp_ram in the soc; the memory side connects directly to the sp_ram port.
- Round-robin arbitration with request locking until grant.
- Per-transaction ID tracking so every response returns to the master that issued it.

---
 rtl/dmem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two masters.
// Tracks outstanding transaction IDs so responses are routed back to their issuer.
module dmem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_err_o,

  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_err_o,

  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,

  output logic                    proto_err_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_WIDTH-1:0] FIFO_DEPTH = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST   = PTR_WIDTH'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    MASTER0 = 1'b0,
    MASTER1 = 1'b1
  } master_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e                lock_state;
  master_e                    lock_id;
  master_e                    rr_prio;

  logic [MAX_OUTSTANDING-1:0] id_fifo;
  logic [PTR_WIDTH-1:0]       wr_ptr;
  logic [PTR_WIDTH-1:0]       rd_ptr;
  logic [CNT_WIDTH-1:0]       count;
  logic                       proto_err_q;

  logic    sel_valid;
  master_e sel_id;
  logic    sel_req;
  logic    fifo_full;
  logic    fifo_empty;
  logic    grant;
  logic    push;
  logic    pop;
  master_e head_id;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  // A pending lock overrides arbitration; on a tie rr_prio names the winner.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = MASTER0;
    if (lock_state == LOCKED) begin
      sel_valid = 1'b1;
      sel_id    = lock_id;
    end else if (m0_req_i && m1_req_i) begin
      sel_valid = 1'b1;
      sel_id    = rr_prio;
    end else if (m0_req_i) begin
      sel_valid = 1'b1;
      sel_id    = MASTER0;
    end else if (m1_req_i) begin
      sel_valid = 1'b1;
      sel_id    = MASTER1;
    end
  end

  assign sel_req    = sel_valid && ((sel_id == MASTER1) ? m1_req_i : m0_req_i);
  assign fifo_full  = (count == FIFO_DEPTH);
  assign fifo_empty = (count == '0);

  assign mem_req_o = sel_req && !fifo_full;
  assign grant     = mem_req_o && mem_gnt_i;
  assign push      = grant;
  assign pop       = mem_rvalid_i && !fifo_empty;

  assign m0_gnt_o = grant && (sel_id == MASTER0);
  assign m1_gnt_o = grant && (sel_id == MASTER1);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_id == MASTER1) begin
        mem_addr_o  = m1_addr_i;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
        mem_wdata_o = m1_wdata_i;
      end else begin
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
        mem_wdata_o = m0_wdata_i;
      end
    end
  end

  // Responses are steered by the oldest outstanding ID with no added latency.
  assign head_id     = master_e'(id_fifo[rd_ptr]);
  assign m0_rvalid_o = pop && (head_id == MASTER0);
  assign m1_rvalid_o = pop && (head_id == MASTER1);
  assign m0_err_o    = m0_rvalid_o && mem_err_i;
  assign m1_err_o    = m1_rvalid_o && mem_err_i;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign proto_err_o = proto_err_q;

  // The lock persists while the selected master keeps requesting but is not
  // yet granted, whether stalled by the memory or by a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state <= UNLOCKED;
      lock_id    <= MASTER0;
      rr_prio    <= MASTER0;
    end else begin
      if (grant) begin
        lock_state <= UNLOCKED;
        rr_prio    <= (sel_id == MASTER0) ? MASTER1 : MASTER0;
      end else if (sel_req) begin
        lock_state <= LOCKED;
        lock_id    <= sel_id;
      end else begin
        lock_state <= UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= sel_id;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      proto_err_q <= 1'b1;
    end
  end

  logic unused_be_width;
  assign unused_be_width = (BE_WIDTH == 0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked against a queue-based
// model of arbitration, locking and response routing.
module tb_dmem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int MAX_OUT = 2;

  logic          clk_i;
  logic          rst_ni;
  logic          req    [2];
  logic [AW-1:0] addr   [2];
  logic          we     [2];
  logic [BW-1:0] be     [2];
  logic [DW-1:0] wdata  [2];
  logic          gnt    [2];
  logic          rvalid [2];
  logic [DW-1:0] rdata  [2];
  logic          err    [2];

  logic          mem_req_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_err_i;
  logic          proto_err_o;

  int n_assert;
  int n_fail;

  // Reference model state
  bit mdl_locked;
  int mdl_lock_id;
  int mdl_prio;
  int mdl_queue[$];
  bit mdl_proto;
  int mdl_last_grant;

  bit exp_sel_valid;
  int exp_sel;
  bit exp_mem_req;
  bit exp_grant;
  bit exp_rvalid [2];
  bit exp_err    [2];

  bit pending [2];

  dmem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .m0_req_i     (req[0]),
    .m0_gnt_o     (gnt[0]),
    .m0_rvalid_o  (rvalid[0]),
    .m0_addr_i    (addr[0]),
    .m0_we_i      (we[0]),
    .m0_be_i      (be[0]),
    .m0_wdata_i   (wdata[0]),
    .m0_rdata_o   (rdata[0]),
    .m0_err_o     (err[0]),
    .m1_req_i     (req[1]),
    .m1_gnt_o     (gnt[1]),
    .m1_rvalid_o  (rvalid[1]),
    .m1_addr_i    (addr[1]),
    .m1_we_i      (we[1]),
    .m1_be_i      (be[1]),
    .m1_wdata_i   (wdata[1]),
    .m1_rdata_o   (rdata[1]),
    .m1_err_o     (err[1]),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .proto_err_o  (proto_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_locked     = 0;
    mdl_lock_id    = 0;
    mdl_prio       = 0;
    mdl_queue.delete();
    mdl_proto      = 0;
    mdl_last_grant = -1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m]   = 1'b0;
      addr[m]  = '0;
      we[m]    = 1'b0;
      be[m]    = '0;
      wdata[m] = '0;
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  task automatic set_master(input int m, input logic r, input logic [AW-1:0] a,
                            input logic w, input logic [BW-1:0] b, input logic [DW-1:0] d);
    req[m]   = r;
    addr[m]  = a;
    we[m]    = w;
    be[m]    = b;
    wdata[m] = d;
  endtask

  // Expected outputs from the current model state and inputs.
  task automatic compute_expected();
    exp_sel_valid = 0;
    exp_sel       = 0;
    if (mdl_locked) begin
      exp_sel_valid = 1;
      exp_sel       = mdl_lock_id;
    end else if (req[0] && req[1]) begin
      exp_sel_valid = 1;
      exp_sel       = mdl_prio;
    end else if (req[0] || req[1]) begin
      exp_sel_valid = 1;
      exp_sel       = req[0] ? 0 : 1;
    end
    exp_mem_req = exp_sel_valid && req[exp_sel] && (mdl_queue.size() < MAX_OUT);
    exp_grant   = exp_mem_req && mem_gnt_i;
    for (int m = 0; m < 2; m++) begin
      exp_rvalid[m] = 0;
      exp_err[m]    = 0;
    end
    if (mem_rvalid_i && mdl_queue.size() > 0) begin
      exp_rvalid[mdl_queue[0]] = 1;
      exp_err[mdl_queue[0]]    = mem_err_i;
    end
  endtask

  task automatic check_output();
    compute_expected();
    check("mem_req", 32'(mem_req_o), 32'(exp_mem_req));
    check("mem_addr", mem_addr_o, exp_sel_valid ? addr[exp_sel] : 32'h0);
    check("mem_we", 32'(mem_we_o), exp_sel_valid ? 32'(we[exp_sel]) : 32'h0);
    check("mem_be", 32'(mem_be_o), exp_sel_valid ? 32'(be[exp_sel]) : 32'h0);
    check("mem_wdata", mem_wdata_o, exp_sel_valid ? wdata[exp_sel] : 32'h0);
    check("proto_err", 32'(proto_err_o), 32'(mdl_proto));
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_gnt", m), 32'(gnt[m]), 32'(exp_grant && exp_sel == m));
      check($sformatf("m%0d_rvalid", m), 32'(rvalid[m]), 32'(exp_rvalid[m]));
      check($sformatf("m%0d_err", m), 32'(err[m]), 32'(exp_err[m]));
      check($sformatf("m%0d_rdata", m), rdata[m], mem_rdata_i);
    end
  endtask

  task automatic update_model();
    mdl_last_grant = -1;
    if (mem_rvalid_i) begin
      if (mdl_queue.size() > 0) void'(mdl_queue.pop_front());
      else mdl_proto = 1;
    end
    if (exp_grant) begin
      mdl_queue.push_back(exp_sel);
      mdl_prio       = 1 - exp_sel;
      mdl_locked     = 0;
      mdl_last_grant = exp_sel;
    end else if (exp_sel_valid && req[exp_sel]) begin
      mdl_locked  = 1;
      mdl_lock_id = exp_sel;
    end else begin
      mdl_locked = 0;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later.
  task automatic run_cycle();
    #1;
    check_output();
    @(posedge clk_i);
    if (rst_ni) update_model();
    @(negedge clk_i);
  endtask

  task automatic apply_stimulus();
    for (int m = 0; m < 2; m++) begin
      if (!pending[m] && $urandom_range(0, 2) != 0) begin
        pending[m] = 1;
        set_master(m, 1'b1, $urandom & 32'hFFFF_FFFC, 1'($urandom), 4'($urandom), $urandom);
      end
      req[m] = pending[m];
    end
    mem_gnt_i    = ($urandom_range(0, 3) != 0);
    mem_rvalid_i = (mdl_queue.size() > 0) && ($urandom_range(0, 1) == 1);
    mem_err_i    = ($urandom_range(0, 7) == 0);
    mem_rdata_i  = $urandom;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    pending[0] = 0;
    pending[1] = 0;
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_output();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single m0 read, response next cycle
    set_master(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
    mem_gnt_i = 1'b1;
    run_cycle();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    run_cycle();
    idle_inputs();

    // Both request continuously; grants must alternate
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        set_master(0, 1'b1, 32'h100 + 32'(c), 1'b1, 4'h3, 32'hA000 + 32'(c));
        set_master(1, 1'b1, 32'h200 + 32'(c), 1'b0, 4'hC, 32'hB000 + 32'(c));
        mem_gnt_i = 1'b1;
      end else begin
        set_master(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_master(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        mem_gnt_i = 1'b0;
      end
      mem_rvalid_i = (c > 0);
      mem_rdata_i  = 32'h5000 + 32'(c);
      run_cycle();
    end
    idle_inputs();

    // m1 stalled by memory, m0 arrives later and must wait
    for (int c = 1; c <= 6; c++) begin
      set_master(1, (c <= 4), 32'h300, 1'b1, 4'hF, 32'h1111_2222);
      set_master(0, (c >= 2 && c <= 5), 32'h400, 1'b0, 4'hF, 32'h0);
      mem_gnt_i    = (c >= 4);
      mem_rvalid_i = (c >= 5);
      mem_rdata_i  = 32'h7000 + 32'(c);
      run_cycle();
    end
    idle_inputs();

    // Fill the ID FIFO, stall on full, then drain
    for (int c = 0; c < 6; c++) begin
      set_master(0, (c == 0 || (c >= 2 && c <= 4)), 32'h500, 1'b0, 4'hF, 32'h0);
      set_master(1, (c == 1), 32'h600, 1'b0, 4'hF, 32'h0);
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (c >= 3);
      mem_err_i    = (c == 4);
      mem_rdata_i  = 32'h8000 + 32'(c);
      run_cycle();
    end
    idle_inputs();

    // Error on m1's response only
    set_master(1, 1'b1, 32'h700, 1'b0, 4'hF, 32'h0);
    mem_gnt_i = 1'b1;
    run_cycle();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    mem_rdata_i  = 32'hBAD0_0001;
    run_cycle();
    idle_inputs();

    // Spurious response with nothing outstanding
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Reset with one response outstanding and m1 locked
    set_master(0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0);
    mem_gnt_i = 1'b1;
    run_cycle();
    idle_inputs();
    set_master(1, 1'b1, 32'h900, 1'b0, 4'hF, 32'h0);
    run_cycle();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_output();
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_master(1, 1'b1, 32'hA00, 1'b0, 4'hF, 32'h0);
    mem_gnt_i = 1'b1;
    run_cycle();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    run_cycle();
    idle_inputs();

    // Randomized traffic with masters holding requests until granted
    for (int c = 0; c < 400; c++) begin
      apply_stimulus();
      run_cycle();
      for (int m = 0; m < 2; m++) begin
        if (mdl_last_grant == m) pending[m] = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
